// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores on a req/ack port, formats data, registers MEM/WB; ALU ops pass in 1 cycle.
// Holds upstream via stall while an access waits for ack; a missing ack past TIMEOUT latches bus_err.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmld,
  input  logic        dmsel,
  input  logic        dmstr,
  input  logic [31:0] aluout,
  input  logic [31:0] rfd2,
  input  logic [31:0] pc,
  input  logic [31:0] IR,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        dmld_nxt,
  output logic [31:0] memout_nxt,
  output logic [31:0] aluout_nxt,
  output logic [31:0] pc_nxt,
  output logic [31:0] IR_nxt,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        op;
  logic        is_load;
  logic        in_idle;
  logic        in_wait;
  logic [1:0]  lane;
  logic [7:0]  rd_byte;
  logic [31:0] memout;

  assign op      = dmld | dmstr;
  assign is_load = dmld & ~dmstr;
  assign in_idle = (state == IDLE);
  assign in_wait = (state == WAIT);
  assign lane    = aluout[1:0];

  assign mem_req   = (in_idle & op) | in_wait;
  assign stall     = (in_idle & op & ~mem_ack) | (in_wait & ~mem_ack) | (state == ERR);
  assign mem_we    = dmstr;
  assign mem_addr  = {aluout[31:2], 2'b00};
  assign mem_be    = dmsel ? (4'b0001 << lane) : 4'hF;
  assign mem_wdata = dmsel ? {4{rfd2[7:0]}} : rfd2;

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (lane)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
  end

  // Non-loads (including store-wins collisions) write zero into memout.
  assign memout = is_load ? (dmsel ? {24'd0, rd_byte} : mem_rdata) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op && !mem_ack) begin
            state    <= WAIT;
            wait_cnt <= 16'd0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state <= IDLE;
          end else if (({1'b0, wait_cnt} + 17'd1) >= TO_LIM) begin
            state   <= ERR;
            bus_err <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ERR: begin
          bus_err <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stalled cycles load a bubble so writeback sees each instruction exactly once.
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      dmld_nxt   <= 1'b0;
      memout_nxt <= 32'd0;
      aluout_nxt <= 32'd0;
      pc_nxt     <= 32'd0;
      IR_nxt     <= 32'd0;
    end else begin
      dmld_nxt   <= is_load;
      memout_nxt <= memout;
      aluout_nxt <= aluout;
      pc_nxt     <= pc;
      IR_nxt     <= IR;
    end
  end

endmodule
